ifetch_stage: RTL
=================

// Module: ifetch_stage
// PURPOSE
//  Instruction fetch stage between the PC stage and decode. Takes the current fetch
//  address, runs a single-outstanding req/gnt/rvalid transaction on instruction
//  memory, and queues {pc, instr} pairs in a small FIFO that feeds decode over a
//  valid/ready handshake. pc_adv tells the PC stage when an address has been consumed.
//  flush discards every queued and in-flight fetch when a branch or PC write redirects.
// PARAMETERS
//  AW     32  address width (pc_addr, imem_addr, id_pc)
//  DW     32  instruction width (imem_rdata, id_instr)
//  DEPTH  2   FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous active-low reset
//  pc_addr     in   AW  fetch address from PC stage
//  pc_adv      out  1   1-cycle pulse: pc_addr consumed, PC may advance
//  flush       in   1   redirect: kill queued and in-flight fetches
//  imem_req    out  1   memory request valid
//  imem_addr   out  AW  memory request address, held stable while imem_req=1
//  imem_gnt    in   1   memory accepts request this cycle (when imem_req=1)
//  imem_rvalid in   1   read data valid (exactly one per granted request)
//  imem_rdata  in   DW  read data
//  id_valid    out  1   FIFO head valid toward decode
//  id_ready    in   1   decode accepts head this cycle
//  id_instr    out  DW  head instruction
//  id_pc       out  AW  head instruction address
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty; pc_adv, imem_req, id_valid = 0; imem_addr, id_instr, id_pc = 0.
//  Credit: occ = fifo_count + (state==WAIT). Issue only when occ < DEPTH, so a response always has a slot.
//  FSM (registered state and outputs):
//   IDLE: if !flush && occ<DEPTH -> REQ; latch imem_addr=pc_addr, imem_req=1 next cycle.
//   REQ : imem_req=1, imem_addr held. On imem_gnt: pc_adv=1 for that cycle, -> WAIT.
//         On flush without gnt: drop req next cycle, -> IDLE. On flush with gnt: -> KILL, no pc_adv.
//   WAIT: on imem_rvalid, push {imem_addr, imem_rdata} and -> IDLE; same-cycle next issue is not
//         allowed (one bubble). On flush: -> KILL, or -> IDLE if imem_rvalid arrives the same cycle
//         (data dropped).
//   KILL: wait for imem_rvalid, drop data, -> IDLE. A new flush while in KILL has no extra effect.
//  pc_adv is combinational from state==REQ && imem_gnt && !flush. Never asserted in any other state.
//  FIFO: id_* come directly from the head entry. id_valid = (count != 0).
//   - Pop when id_valid && id_ready. Push and pop in the same cycle leave count unchanged (legal when full).
//   - Latency: rvalid at edge N -> id_valid=1 after edge N; best-case throughput is 1 instr per 3 cycles
//     for a 0-wait-state memory.
//  flush: FIFO count and pointers clear at the same edge, so id_valid=0 next cycle. Flush overrides a
//   same-cycle push or pop. id_ready is ignored during flush.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits and never exceeds DEPTH.
//  The design assumes no imem_rvalid arrives in IDLE or REQ. A stray rvalid in those states is ignored.
//  Asynchronous reset mid-transaction returns to IDLE. Memory must also be reset.
// TESTING
//  1 Single fetch: pc_addr=0x100, gnt at first req cycle, rvalid 2 cycles later with 0xE3A00001
//    -> pc_adv one pulse; id_valid=1 with id_pc=0x100, id_instr=0xE3A00001.
//  2 Backpressure: id_ready=0, three fetches attempted (DEPTH=2) -> 2 entries queued, no third
//    imem_req; raise id_ready -> entries in order, then fetching resumes.
//  3 Flush in WAIT: gnt for 0x200, flush before rvalid -> KILL, rvalid data dropped, id_valid
//    stays 0; next request uses the new pc_addr (0x400).
//  4 Flush with gnt same cycle -> no pc_adv, transaction killed; flush with 1 queued entry
//    -> id_valid=0 next cycle.
//  5 Full + simultaneous push/pop: FIFO at DEPTH-1 plus outstanding, rvalid and id_ready same
//    cycle -> count unchanged, order preserved.
//  6 reset_n low during REQ -> imem_req=0 and id_valid=0 immediately (asynchronous), state IDLE on release.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch into a small
// {pc, instr} FIFO toward decode, with credit-based issue and flush-kill.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no transaction; issue next cycle if credit allows
//   S_REQ  | imem_req high, imem_addr held until imem_gnt
//   S_WAIT | granted, waiting for imem_rvalid to push into the FIFO
//   S_KILL | granted fetch was flushed; swallow its imem_rvalid
module ifetch_stage #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] pc_addr,
   output logic          pc_adv,
   input  logic          flush,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [DW-1:0] imem_rdata,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [DW-1:0] id_instr,
   output logic [AW-1:0] id_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_KILL} state_t;

   state_t        state, state_nxt;
   logic          issue, push, pop;
   logic [CW-1:0] count, occ;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [AW-1:0] fifo_pc    [DEPTH];
   logic [DW-1:0] fifo_instr [DEPTH];

   // A granted fetch reserves its FIFO slot so the response can never overflow.
   assign occ      = count + CW'(state == S_WAIT);
   assign imem_req = (state == S_REQ);
   assign pc_adv   = (state == S_REQ) && imem_gnt && !flush;
   assign id_valid = (count != '0);
   assign id_pc    = fifo_pc[rd_ptr];
   assign id_instr = fifo_instr[rd_ptr];
   assign pop      = id_valid && id_ready && !flush;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!flush && (occ < CW'(DEPTH))) begin
               issue     = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (imem_gnt)   state_nxt = flush ? S_KILL : S_WAIT;
            else if (flush) state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               push      = !flush;
               state_nxt = S_IDLE;
            end else if (flush) begin
               state_nxt = S_KILL;
            end
         end
         S_KILL: begin
            if (imem_rvalid) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         imem_addr <= '0;
      end else begin
         state <= state_nxt;
         if (issue) imem_addr <= pc_addr;
      end
   end

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]    <= imem_addr;
            fifo_instr[wr_ptr] <= imem_rdata;
            wr_ptr             <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
